// File: rtl/sram_bank_responder_if.sv
// Request/response bundle between an SRAM controller (master) and one or more
// bank responders (slave); the address, data and write-enable wires are shared by all banks.
interface sram_bank_responder_if #(
    parameter int N_SRAM = 1
);
    logic [N_SRAM-1:0] sram_en;
    logic              wen;
    logic [31:0]       addr;
    logic [3:0]        byte_en;
    logic [31:0]       ram_wData;
    logic [31:0]       ram_rData;
    logic              sram_wait;

    modport master (
        output sram_en, wen, addr, byte_en, ram_wData,
        input  ram_rData, sram_wait
    );

    modport slave (
        input  sram_en, wen, addr, byte_en, ram_wData,
        output ram_rData, sram_wait
    );
endinterface

// File: rtl/sram_bank_responder.sv
// Single-bank 32-bit SRAM responder with configurable wait states.
// Define SRAM_PROTOCOL_CHECK_EN to add the sticky proto_err output.
module sram_bank_responder #(
    parameter int          N_SRAM         = 1,
    parameter int          BANK_ID        = 0,
    parameter bit          INVERT_CE_EN   = 1'b0,
    parameter bit          INVERT_BYTE_EN = 1'b0,
    parameter logic [31:0] SRAM_DEPTH     = 32'h0000_3fff,
    parameter int          WAIT_STATES    = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    sram_bank_responder_if.slave bus
`ifdef SRAM_PROTOCOL_CHECK_EN
    ,
    output logic                 proto_err
`endif
);

    localparam int                AW       = (SRAM_DEPTH > 1) ? $clog2(SRAM_DEPTH) : 1;
    localparam logic [N_SRAM-1:0] SEL_MASK = N_SRAM'(1) << BANK_ID;
    localparam bit                HAS_WAIT = (WAIT_STATES != 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] rdata_q;
    logic [31:0] mem [SRAM_DEPTH];

    // Request captured on entry to BUSY; live inputs are ignored until commit.
    logic        lat_wen;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_lanes;

    logic        req;
    logic [3:0]  lanes;
    logic        commit;
    logic        c_wen;
    logic        c_in_range;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_lanes;
    logic [AW-1:0] c_idx;

    assign req   = |((bus.sram_en ^ {N_SRAM{INVERT_CE_EN}}) & SEL_MASK);
    assign lanes = bus.byte_en ^ {4{INVERT_BYTE_EN}};

    // Zero-wait accesses commit straight from the bus; otherwise from the latched copy.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        commit  = 1'b0;
        c_wen   = bus.wen;
        c_addr  = bus.addr;
        c_wdata = bus.ram_wData;
        c_lanes = lanes;
        if (state == IDLE) begin
            commit = req && !HAS_WAIT;
        end else begin
            commit  = (cnt == 4'd0);
            c_wen   = lat_wen;
            c_addr  = lat_addr;
            c_wdata = lat_wdata;
            c_lanes = lat_lanes;
        end
    end

    assign c_in_range = (c_addr < SRAM_DEPTH);
    assign c_idx      = c_addr[AW-1:0];

    assign bus.sram_wait = HRESETn && ((state == IDLE) ? (req && HAS_WAIT) : (cnt != 4'd0));
    assign bus.ram_rData = rdata_q;

    // NOTE: storage has no reset branch so it maps onto block RAM; a write is
    // also suppressed on a reset edge so an interrupted access never lands.
    always_ff @(posedge HCLK) begin
        if (HRESETn && commit && c_wen && c_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (c_lanes[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && HAS_WAIT) begin
                        state     <= BUSY;
                        cnt       <= 4'(WAIT_STATES - 1);
                        lat_wen   <= bus.wen;
                        lat_addr  <= bus.addr;
                        lat_wdata <= bus.ram_wData;
                        lat_lanes <= lanes;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                    else             state <= IDLE;
                end
            endcase
            if (commit && !c_wen) rdata_q <= c_in_range ? mem[c_idx] : 32'hBAD1_BAD1;
        end
    end

`ifdef SRAM_PROTOCOL_CHECK_EN
    // Flags a controller that changes or drops its request mid-access, or targets a missing word.
    logic busy_mismatch;

    assign busy_mismatch = !req || (bus.addr != lat_addr) || (bus.wen != lat_wen) ||
                           (lanes != lat_lanes) || (lat_wen && (bus.ram_wData != lat_wdata));

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            proto_err <= 1'b0;
        end else if (((state == BUSY) && busy_mismatch) || (commit && !c_in_range)) begin
            proto_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_bank_responder.sv
// Bench for sram_bank_responder: a 2-wait-state bank (index 1 of 2, active-low select) and a
// zero-wait bank (active-low lanes) on shared buses, checked every cycle against a transaction model.
module tb_sram_bank_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  en_a;
    logic [0:0]  en_b;
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  byte_en;
    logic [31:0] wdata;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state: expected outputs per bank and word contents keyed by {bank, addr}.
    logic        exp_wait  [2];
    logic [31:0] exp_rdata [2];
    logic        exp_proto [2];
    logic [31:0] mdl_mem [logic [32:0]];

    always #5 clk = ~clk;

    sram_bank_responder_if #(.N_SRAM(2)) bus_a ();
    sram_bank_responder_if #(.N_SRAM(1)) bus_b ();

    assign bus_a.sram_en   = en_a;
    assign bus_a.wen       = wen;
    assign bus_a.addr      = addr;
    assign bus_a.byte_en   = byte_en;
    assign bus_a.ram_wData = wdata;
    assign bus_b.sram_en   = en_b;
    assign bus_b.wen       = wen;
    assign bus_b.addr      = addr;
    assign bus_b.byte_en   = byte_en;
    assign bus_b.ram_wData = wdata;

`ifdef SRAM_PROTOCOL_CHECK_EN
    logic proto_a, proto_b;
`endif

    sram_bank_responder #(
        .N_SRAM(2), .BANK_ID(1), .INVERT_CE_EN(1'b1), .INVERT_BYTE_EN(1'b0),
        .SRAM_DEPTH(32'h0000_3fff), .WAIT_STATES(2)
    ) dut_a (
        .HCLK(clk), .HRESETn(rst_n), .bus(bus_a)
`ifdef SRAM_PROTOCOL_CHECK_EN
        , .proto_err(proto_a)
`endif
    );

    sram_bank_responder #(
        .N_SRAM(1), .BANK_ID(0), .INVERT_CE_EN(1'b0), .INVERT_BYTE_EN(1'b1),
        .SRAM_DEPTH(32'h0000_3fff), .WAIT_STATES(0)
    ) dut_b (
        .HCLK(clk), .HRESETn(rst_n), .bus(bus_b)
`ifdef SRAM_PROTOCOL_CHECK_EN
        , .proto_err(proto_b)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("wait_a",  {31'b0, bus_a.sram_wait}, {31'b0, exp_wait[0]});
            check("rdata_a", bus_a.ram_rData, exp_rdata[0]);
            check("wait_b",  {31'b0, bus_b.sram_wait}, {31'b0, exp_wait[1]});
            check("rdata_b", bus_b.ram_rData, exp_rdata[1]);
`ifdef SRAM_PROTOCOL_CHECK_EN
            check("proto_a", {31'b0, proto_a}, {31'b0, exp_proto[0]});
            check("proto_b", {31'b0, proto_b}, {31'b0, exp_proto[1]});
`endif
        end
    end

    task automatic drive_idle();
        en_a    = 2'b10;
        en_b    = 1'b0;
        wen     = 1'b0;
        addr    = 32'h0;
        byte_en = 4'h0;
        wdata   = 32'h0;
    endtask

    // Applies one completed access to the model.
    task automatic model_commit(input int d, input logic w, input logic [31:0] a,
                                input logic [3:0] ln, input logic [31:0] wd);
        logic [32:0] key = {d[0], a};
        logic [31:0] word;
        bit          inr = (a < 32'h0000_3fff);
        if (!inr) exp_proto[d] = 1'b1;
        if (w) begin
            if (inr) begin
                word = mdl_mem.exists(key) ? mdl_mem[key] : 32'h0;
                for (int i = 0; i < 4; i++) if (ln[i]) word[8*i +: 8] = wd[8*i +: 8];
                mdl_mem[key] = word;
            end
        end else begin
            exp_rdata[d] = inr ? mdl_mem[key] : 32'hBAD1_BAD1;
        end
    endtask

    // One access to bank d (0 = A, 1 = B), ln is the effective lane mask. Called at posedge+1.
    // drop deselects the bank after the accepting edge, which must not abort the access.
    task automatic access(input int d, input logic w, input logic [31:0] a, input logic [3:0] ln,
                          input logic [31:0] wd, input bit drop = 1'b0);
        int ws = (d == 0) ? 2 : 0;
        en_a    = (d == 0) ? 2'b01 : 2'b10;
        en_b    = (d == 1) ? 1'b1 : 1'b0;
        wen     = w;
        addr    = a;
        byte_en = ln ^ ((d == 1) ? 4'hF : 4'h0);
        wdata   = wd;
        for (int k = 0; k <= ws; k++) begin
            exp_wait[d] = (k < ws);
            @(posedge clk);
            #1;
            if (drop && k == 0) en_a = 2'b10;
            if (drop && k >= 1 && k < ws) exp_proto[d] = 1'b1;
        end
        model_commit(d, w, a, ln, wd);
        exp_wait[d] = 1'b0;
        drive_idle();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            exp_wait[i]  = 1'b0;
            exp_rdata[i] = 32'h0;
            exp_proto[i] = 1'b0;
        end
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("reset_rdata_a", bus_a.ram_rData, 32'h0);
        check("reset_rdata_b", bus_b.ram_rData, 32'h0);
        check("reset_wait_a",  {31'b0, bus_a.sram_wait}, 32'h0);

        // Full write then read; data lands in cycle W+1 = 3.
        access(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        access(0, 1'b0, 32'h10, 4'hF, 32'h0);
        check("read_full_a", bus_a.ram_rData, 32'hDEAD_BEEF);

        // Partial write of lanes 0 and 2; read with a single lane to show reads are not masked.
        access(0, 1'b1, 32'h10, 4'b0101, 32'h1122_3344);
        access(0, 1'b0, 32'h10, 4'b0001, 32'h0);
        check("read_partial_a", bus_a.ram_rData, 32'hDE22_BE44);

        // Boundary: last valid word, first missing word, and a far-out address.
        access(0, 1'b1, 32'h3ffe, 4'hF, 32'h5A5A_0001);
        access(0, 1'b0, 32'h3ffe, 4'hF, 32'h0);
        check("read_last_word", bus_a.ram_rData, 32'h5A5A_0001);
        access(0, 1'b0, 32'h3fff, 4'hF, 32'h0);
        check("read_depth_oor", bus_a.ram_rData, 32'hBAD1_BAD1);
        access(0, 1'b0, 32'h4000, 4'hF, 32'h0);
        check("read_4000_oor", bus_a.ram_rData, 32'hBAD1_BAD1);
`ifdef SRAM_PROTOCOL_CHECK_EN
        check("proto_after_oor", {31'b0, proto_a}, 32'h1);
`endif

        // Out-of-range write whose low bits alias 0x10 must not disturb it; rData holds across writes.
        access(0, 1'b1, 32'h4010, 4'hF, 32'hFFFF_FFFF);
        check("rdata_hold_write", bus_a.ram_rData, 32'hBAD1_BAD1);
        access(0, 1'b0, 32'h10, 4'hF, 32'h0);
        check("read_after_oor_wr", bus_a.ram_rData, 32'hDE22_BE44);

        // Reset in the middle of a BUSY write discards it.
        access(0, 1'b1, 32'h20, 4'hF, 32'h1234_5678);
        en_a    = 2'b01;
        wen     = 1'b1;
        addr    = 32'h20;
        byte_en = 4'hF;
        wdata   = 32'hCAFE_F00D;
        exp_wait[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_wait[0] = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_rdata[i] = 32'h0;
            exp_proto[i] = 1'b0;
        end
        drive_idle();
        check("rst_mid_rdata", bus_a.ram_rData, 32'h0);
        check("rst_mid_wait",  {31'b0, bus_a.sram_wait}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(0, 1'b0, 32'h20, 4'hF, 32'h0);
        check("read_after_rst", bus_a.ram_rData, 32'h1234_5678);

        // Back-to-back accesses with no idle gap, then deselect mid-BUSY.
        access(0, 1'b0, 32'h10, 4'hF, 32'h0);
        access(0, 1'b0, 32'h20, 4'hF, 32'h0);
        check("b2b_second_a", bus_a.ram_rData, 32'h1234_5678);
        access(0, 1'b1, 32'h30, 4'hF, 32'h1357_2468, 1'b1);
        access(0, 1'b0, 32'h30, 4'hF, 32'h0);
        check("read_after_drop", bus_a.ram_rData, 32'h1357_2468);

        // Zero-wait bank: back-to-back writes and reads, bank A must ignore this traffic.
        access(1, 1'b1, 32'h0, 4'hF, 32'h0000_00A0);
        access(1, 1'b1, 32'h1, 4'hF, 32'h0000_00A1);
        access(1, 1'b1, 32'h2, 4'hF, 32'h0000_00A2);
        access(1, 1'b0, 32'h0, 4'hF, 32'h0);
        check("b_read_0", bus_b.ram_rData, 32'h0000_00A0);
        access(1, 1'b0, 32'h1, 4'hF, 32'h0);
        access(1, 1'b0, 32'h2, 4'hF, 32'h0);
        check("b_read_2", bus_b.ram_rData, 32'h0000_00A2);
        access(1, 1'b1, 32'h1, 4'h0, 32'hFFFF_FFFF);
        access(1, 1'b1, 32'h2, 4'b1000, 32'h7700_0000);
        access(1, 1'b0, 32'h1, 4'hF, 32'h0);
        check("b_no_lanes", bus_b.ram_rData, 32'h0000_00A1);
        access(1, 1'b0, 32'h2, 4'hF, 32'h0);
        check("b_lane3", bus_b.ram_rData, 32'h7700_00A2);
        check("a_untouched", bus_a.ram_rData, 32'h1357_2468);

        // Bank A idle select pattern with a live request on the bus.
        en_a = 2'b10;
        wen  = 1'b0;
        addr = 32'h10;
        @(negedge clk);
        check("deselected_wait", {31'b0, bus_a.sram_wait}, 32'h0);
        @(posedge clk);
        #1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
